// File: rtl/spi_regfile_pkg.sv
// spi_regfile_pkg: shared constants for the SPI register file.
//   - fixed register addresses and the read/write bit of the command byte
//   - FSM state encoding (also visible on the top-level o_state debug port)
//   - is_rw(): tells writable addresses apart from read-only ones
package spi_regfile_pkg;

  localparam int ADDR_W = 7;

  typedef logic [ADDR_W-1:0] addr_t;
  typedef logic [1:0]        state_t;

  localparam addr_t ADDR_WHO_AM_I = 7'd0;
  localparam addr_t ADDR_CTRL     = 7'd1;
  localparam addr_t ADDR_STATUS   = 7'd2;
  localparam addr_t ADDR_SCRATCH  = 7'd3;

  localparam int CMD_RD_BIT = 7;

  localparam state_t ST_IDLE = 2'd0;
  localparam state_t ST_CMD  = 2'd1;
  localparam state_t ST_RD   = 2'd2;
  localparam state_t ST_WR   = 2'd3;

  // Only answers for addresses inside the map; the caller does the range check
  // because the map size is a parameter of the top module.
  function automatic logic is_rw(input addr_t a);
    return (a != ADDR_WHO_AM_I) && (a != ADDR_STATUS);
  endfunction

endpackage

// File: rtl/spi_regfile_if.sv
// spi_regfile_if: byte-level link between spi_slave (master side) and the
// register file (slave side).
//   rx_done  1  one-cycle strobe: a full byte has been received
//   rx_data  8  received byte, valid only while rx_done is high
//   tx_data  8  byte spi_slave shifts out in the next byte slot
// Handshake: rx_done is a pure strobe with no ready/backpressure; the slave
// must accept every byte in the cycle rx_done is high. tx_data is a level
// that the slave keeps stable until it chooses to change it.
interface spi_regfile_if;
  logic       rx_done;
  logic [7:0] rx_data;
  logic [7:0] tx_data;

  modport master (output rx_done, output rx_data, input tx_data);
  modport slave  (input rx_done, input rx_data, output tx_data);
endinterface

// File: rtl/spi_regfile_cs_sync.sv
// spi_cs_sync: brings the asynchronous SPI chip select into the i_clk domain
// and produces one-cycle edge pulses.
//   i_clk, i_rst  clock / synchronous active-high reset
//   i_cs_n        raw chip select (active low, asynchronous)
//   o_fall        one-cycle pulse: CS asserted (transaction start)
//   o_rise        one-cycle pulse: CS released (transaction end)
// Reset state is "CS deasserted", so a CS held low across reset is seen as
// a fresh falling edge once the synchroniser has refilled.
module spi_cs_sync (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_cs_n,
  output logic o_fall,
  output logic o_rise
);

  logic meta_q, sync_q, prev_q;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      meta_q <= 1'b1;
      sync_q <= 1'b1;
      prev_q <= 1'b1;
    end else begin
      meta_q <= i_cs_n;
      sync_q <= meta_q;
      prev_q <= sync_q;
    end
  end

  assign o_fall = prev_q & ~sync_q;
  assign o_rise = ~prev_q & sync_q;

endmodule

// File: rtl/spi_regfile.sv
// spi_regfile: multi-byte register file behind the byte-level SPI slave.
// A transaction is a command byte {rd, addr[6:0]} followed by data bytes.
// Optional feature macro: SPI_REGFILE_AUTOINC_EN (defined: burst bytes walk
// consecutive registers; undefined: every burst byte targets the same one).
// Ports:
//   i_clk, i_rst   clock / synchronous active-high reset
//   i_cs_n         raw SPI chip select (synchronised internally)
//   spi_bus        byte link to spi_slave (rx_done/rx_data in, tx_data out)
//   i_status       live status, readable at address 2
//   o_led          CTRL[0];  o_led_en constant 1
//   o_regs         flat image, register k at [8k+7:8k]
//   o_wr_stb       one-cycle pulse per accepted write, o_wr_addr its address
//   o_addr_err     one-cycle pulse per data byte aimed at an unmapped address
//   o_state        FSM state (debug)
module spi_regfile
  import spi_regfile_pkg::*;
#(
  parameter int         NUM_REGS    = 8,
  parameter logic [7:0] WHO_AM_I    = 8'h8F,
  parameter logic [7:0] RST_SCRATCH = 8'h00
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_cs_n,
  spi_regfile_if.slave          spi_bus,
  input  logic [7:0]            i_status,
  output logic                  o_led,
  output logic                  o_led_en,
  output logic [NUM_REGS*8-1:0] o_regs,
  output logic                  o_wr_stb,
  output logic [ADDR_W-1:0]     o_wr_addr,
  output logic                  o_addr_err,
  output state_t                o_state
);

  localparam int         IDX_W      = $clog2(NUM_REGS);
  localparam logic [7:0] NUM_REGS_W = 8'(NUM_REGS);
  localparam addr_t      LAST_ADDR  = 7'(NUM_REGS - 1);

  logic       cs_fall, cs_rise;
  state_t     state_q;
  addr_t      addr_q;
  logic [7:0] tx_q;
  logic       wr_stb_q, addr_err_q;
  addr_t      wr_addr_q;
  logic [7:0] regs_q [NUM_REGS];

  spi_cs_sync u_cs_sync (
    .i_clk  (i_clk),
    .i_rst  (i_rst),
    .i_cs_n (i_cs_n),
    .o_fall (cs_fall),
    .o_rise (cs_rise)
  );

  function automatic logic in_range(input addr_t a);
    return {1'b0, a} < NUM_REGS_W;
  endfunction

  // Addresses 0 and 2 are served from constants / the live input; their
  // storage slots exist only to keep indexing uniform and are never written.
  function automatic logic [7:0] rd_val(input addr_t a);
    if (!in_range(a))             return 8'h00;
    else if (a == ADDR_WHO_AM_I)  return WHO_AM_I;
    else if (a == ADDR_STATUS)    return i_status;
    else                          return regs_q[a[IDX_W-1:0]];
  endfunction

  // Out-of-range command addresses keep counting to 127 and wrap via the
  // natural 7-bit overflow.
  function automatic addr_t next_addr(input addr_t a);
`ifdef SPI_REGFILE_AUTOINC_EN
    if (a == LAST_ADDR) return '0;
    return a + 7'd1;
`else
    return a;
`endif
  endfunction

  addr_t nxt;
  assign nxt = next_addr(addr_q);

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q    <= ST_IDLE;
      addr_q     <= '0;
      tx_q       <= 8'h00;
      wr_stb_q   <= 1'b0;
      wr_addr_q  <= '0;
      addr_err_q <= 1'b0;
      for (int k = 0; k < NUM_REGS; k++) begin
        regs_q[k] <= (k == int'(ADDR_SCRATCH)) ? RST_SCRATCH : 8'h00;
      end
    end else begin
      wr_stb_q   <= 1'b0;
      addr_err_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          // The command byte slot shifts out the current status.
          if (cs_fall) begin
            state_q <= ST_CMD;
            tx_q    <= i_status;
          end
        end
        ST_CMD: begin
          if (spi_bus.rx_done) begin
            addr_q <= spi_bus.rx_data[ADDR_W-1:0];
            if (spi_bus.rx_data[CMD_RD_BIT]) begin
              state_q <= ST_RD;
              tx_q    <= rd_val(spi_bus.rx_data[ADDR_W-1:0]);
            end else begin
              state_q <= ST_WR;
            end
          end
        end
        ST_RD: begin
          // The byte just shifted out came from addr_q; flag it if unmapped.
          if (spi_bus.rx_done) begin
            addr_q     <= nxt;
            tx_q       <= rd_val(nxt);
            addr_err_q <= !in_range(addr_q);
          end
        end
        default: begin // ST_WR
          if (spi_bus.rx_done) begin
            if (!in_range(addr_q)) begin
              addr_err_q <= 1'b1;
            end else if (is_rw(addr_q)) begin
              regs_q[addr_q[IDX_W-1:0]] <= spi_bus.rx_data;
              wr_stb_q  <= 1'b1;
              wr_addr_q <= addr_q;
            end
            addr_q <= nxt;
          end
        end
      endcase
      // Placed last so a byte completing with CS release is still committed.
      if (cs_rise) state_q <= ST_IDLE;
    end
  end

  for (genvar k = 0; k < NUM_REGS; k++) begin : g_img
    assign o_regs[8*k +: 8] = rd_val(7'(k));
  end

  assign spi_bus.tx_data = tx_q;
  assign o_led           = regs_q[ADDR_CTRL[IDX_W-1:0]][0];
  assign o_led_en        = 1'b1;
  assign o_wr_stb        = wr_stb_q;
  assign o_wr_addr       = wr_addr_q;
  assign o_addr_err      = addr_err_q;
  assign o_state         = state_q;

endmodule

// File: tb/tb_spi_regfile.sv
module tb_spi_regfile;
  import spi_regfile_pkg::*;

  localparam int NR = 8;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic cs_n = 1'b1;
  logic [7:0] status = 8'h5A;
  always #5 clk = ~clk;

  logic            led, led_en, wr_stb, addr_err;
  logic [6:0]      wr_addr;
  logic [NR*8-1:0] regs;
  state_t          state;

  spi_regfile_if bus ();

  spi_regfile #(.NUM_REGS(NR), .WHO_AM_I(8'h8F), .RST_SCRATCH(8'h00)) dut (
    .i_clk      (clk),
    .i_rst      (rst),
    .i_cs_n     (cs_n),
    .spi_bus    (bus),
    .i_status   (status),
    .o_led      (led),
    .o_led_en   (led_en),
    .o_regs     (regs),
    .o_wr_stb   (wr_stb),
    .o_wr_addr  (wr_addr),
    .o_addr_err (addr_err),
    .o_state    (state)
  );

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_fail   = 0;
  int err_count = 0;
  logic [8:0] exp_q[$];      // {check_enable, expected MISO byte}
  logic [6:0] exp_wr_q[$];   // expected write addresses
  logic [7:0] model [NR];
  logic [8:0] mon_e;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [63:0] image();
    logic [63:0] img;
    for (int k = 0; k < NR; k++) begin
      img[8*k +: 8] = (k == 0) ? 8'h8F : (k == 2) ? status : model[k];
    end
    return img;
  endfunction

  // Monitor: MISO byte is whatever tx_data holds when the byte completes.
  always @(negedge clk) begin
    if (bus.rx_done) begin
      if (exp_q.size() == 0) begin
        n_checks++; n_fail++;
        $display("FAIL miso_underflow: got byte %0h expected none", bus.tx_data);
      end else begin
        mon_e = exp_q.pop_front();
        if (mon_e[8]) check("miso", 64'(bus.tx_data), 64'(mon_e[7:0]));
      end
    end
    if (wr_stb) begin
      if (exp_wr_q.size() == 0) begin
        n_checks++; n_fail++;
        $display("FAIL unexpected_wr: got addr %0h expected no write", wr_addr);
      end else begin
        check("wr_addr", 64'(wr_addr), 64'(exp_wr_q.pop_front()));
      end
    end
    if (addr_err) err_count++;
  end

  // ---------------- driver tasks ----------------
  task automatic send(input logic [7:0] b, input logic chk, input logic [7:0] exp);
    exp_q.push_back({chk, exp});
    @(posedge clk); #1;
    bus.rx_data = b;
    bus.rx_done = 1'b1;
    @(posedge clk); #1;
    bus.rx_done = 1'b0;
    repeat (2) @(posedge clk);
  endtask

  task automatic cs_start();
    @(posedge clk); #1 cs_n = 1'b0;
    repeat (5) @(posedge clk);
    #1;
  endtask

  task automatic cs_end();
    @(posedge clk); #1 cs_n = 1'b1;
    repeat (5) @(posedge clk);
    #1;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    bus.rx_done = 1'b0;
    bus.rx_data = 8'h00;
    for (int k = 0; k < NR; k++) model[k] = 8'h00;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    // reset state
    check("rst_state",  64'(state), 64'(ST_IDLE));
    check("rst_tx",     64'(bus.tx_data), 64'h00);
    check("rst_led",    64'(led), 64'h0);
    check("rst_led_en", 64'(led_en), 64'h1);
    check("rst_wr_stb", 64'(wr_stb), 64'h0);
    check("rst_image",  regs, image());

    // zero-byte transaction
    cs_start();
    check("cmd_state", 64'(state), 64'(ST_CMD));
    cs_end();
    check("idle_state", 64'(state), 64'(ST_IDLE));

    // single-byte read of WHO_AM_I
    cs_start();
    send(8'h80, 1'b1, 8'h5A);
    send(8'h00, 1'b1, 8'h8F);
    cs_end();

    // write CTRL=1, read back, clear
    cs_start();
    exp_wr_q.push_back(7'd1);
    send(8'h01, 1'b1, 8'h5A);
    send(8'h01, 1'b0, 8'h00);
    cs_end();
    model[1] = 8'h01;
    check("led_on", 64'(led), 64'h1);
    check("image_ctrl", regs, image());
    cs_start();
    send(8'h81, 1'b1, 8'h5A);
    send(8'h00, 1'b1, 8'h01);
    cs_end();
    cs_start();
    exp_wr_q.push_back(7'd1);
    send(8'h01, 1'b1, 8'h5A);
    send(8'h00, 1'b0, 8'h00);
    cs_end();
    model[1] = 8'h00;
    check("led_off", 64'(led), 64'h0);

    // STATUS read and RO write ignored
    status = 8'h3C;
    cs_start();
    send(8'h82, 1'b1, 8'h3C);
    send(8'h00, 1'b1, 8'h3C);
    cs_end();
    cs_start();
    send(8'h02, 1'b1, 8'h3C);
    send(8'hEE, 1'b0, 8'h00);
    cs_end();
    check("image_ro", regs, image());
    status = 8'h5A;

`ifdef SPI_REGFILE_AUTOINC_EN
    // burst with wrap: 6,7 written, address 0 is RO
    cs_start();
    exp_wr_q.push_back(7'd6);
    exp_wr_q.push_back(7'd7);
    send(8'h06, 1'b1, 8'h5A);
    send(8'hA1, 1'b0, 8'h00);
    send(8'hB2, 1'b0, 8'h00);
    send(8'hC3, 1'b0, 8'h00);
    cs_end();
    model[6] = 8'hA1;
    model[7] = 8'hB2;
    check("burst_image", regs, image());
    cs_start();
    send(8'h86, 1'b1, 8'h5A);
    send(8'h00, 1'b1, 8'hA1);
    send(8'h00, 1'b1, 8'hB2);
    send(8'h00, 1'b1, 8'h8F);
    cs_end();
`else
    // fixed address: all bytes hit register 4
    cs_start();
    exp_wr_q.push_back(7'd4);
    exp_wr_q.push_back(7'd4);
    exp_wr_q.push_back(7'd4);
    send(8'h04, 1'b1, 8'h5A);
    send(8'h11, 1'b0, 8'h00);
    send(8'h22, 1'b0, 8'h00);
    send(8'h33, 1'b0, 8'h00);
    cs_end();
    model[4] = 8'h33;
    check("fixed_image", regs, image());
    cs_start();
    send(8'h84, 1'b1, 8'h5A);
    send(8'h00, 1'b1, 8'h33);
    send(8'h00, 1'b1, 8'h33);
    cs_end();
`endif

    // out-of-range read and write
    check("err_none", 64'(err_count), 64'd0);
    cs_start();
    send(8'h8A, 1'b1, 8'h5A);
    send(8'h00, 1'b1, 8'h00);
    cs_end();
    check("err_rd", 64'(err_count), 64'd1);
    cs_start();
    send(8'h0A, 1'b1, 8'h5A);
    send(8'h55, 1'b0, 8'h00);
    cs_end();
    check("err_wr", 64'(err_count), 64'd2);
    check("oor_image", regs, image());

    // SCRATCH write, then reset mid-write
    cs_start();
    exp_wr_q.push_back(7'd3);
    send(8'h03, 1'b1, 8'h5A);
    send(8'h77, 1'b0, 8'h00);
    cs_end();
    model[3] = 8'h77;
    check("scratch_set", regs, image());
    cs_start();
    send(8'h03, 1'b1, 8'h5A);
    @(posedge clk); #1 rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    for (int k = 0; k < NR; k++) model[k] = 8'h00;
    check("abort_state", 64'(state), 64'(ST_IDLE));
    check("abort_tx", 64'(bus.tx_data), 64'h00);
    check("abort_image", regs, image());
    send(8'h42, 1'b0, 8'h00);
    cs_end();
    check("abort_no_write", regs, image());
    check("abort_err", 64'(err_count), 64'd2);
    check("wr_q_empty", 64'(exp_wr_q.size()), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
